// File: rtl/amiq_dvcon_blue_field_buffer.sv
// amiq_dvcon_blue_field_buffer
// DEPTH-entry first-word-fall-through FIFO carrying NUM_FIELDS x FIELD_W beats
// between the blue VIP driver and the DUT core, with a saturating count of
// producer stall cycles.
// Optional feature macro: AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN adds a per-beat
// XOR checksum (out_csum) and a sticky checksum error flag (csum_err).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. in_ready depends only on level and in_valid never feeds back into it;
// out_valid depends only on level. A producer that is stalled holds in_fields
// stable. A full buffer refuses a push even when a pop happens in the same cycle.
module amiq_dvcon_blue_field_buffer #(
    parameter int NUM_FIELDS  = 3,
    parameter int FIELD_W     = 32,
    parameter int DEPTH       = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0] in_fields,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0] out_fields,
    output logic [$clog2(DEPTH):0]        level,
    output logic [STALL_CNT_W-1:0]        stall_cnt
`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
    ,
    input  logic                          in_csum_chk,
    output logic [FIELD_W-1:0]            out_csum,
    output logic                          csum_err
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int DATA_W = NUM_FIELDS * FIELD_W;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Handshake decode; ready/valid come from level only.
    always_comb begin
        in_ready   = (level != LVL_FULL);
        out_valid  = (level != '0);
        push       = in_valid & in_ready;
        pop        = out_valid & out_ready;
        out_fields = out_valid ? mem[rd_ptr] : '0;
    end

    // Beat storage; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= in_fields;
        end
    end

    // Pointers and occupancy; power-of-two DEPTH makes the pointer wrap natural.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Count cycles where the producer offers a beat the buffer cannot take; no wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
    logic [FIELD_W-1:0] csum_mem [DEPTH];
    logic [FIELD_W-1:0] in_csum;

    // XOR of all incoming fields, computed at push time.
    always_comb begin
        in_csum = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            in_csum = in_csum ^ in_fields[i*FIELD_W +: FIELD_W];
        end
        out_csum = out_valid ? csum_mem[rd_ptr] : '0;
    end

    // Checksum storage travels alongside the beat at the same index.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            csum_mem[wr_ptr] <= in_csum;
        end
    end

    // Sticky error: any checked push with nonzero XOR sets it until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_err <= 1'b0;
        end else if (push && in_csum_chk && (in_csum != '0)) begin
            csum_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_amiq_dvcon_blue_field_buffer.sv
// Bench for amiq_dvcon_blue_field_buffer: directed scenarios plus a random run,
// all checked against a queue-based model of an ordered bounded buffer.
module tb_amiq_dvcon_blue_field_buffer;

    localparam int NF    = 3;
    localparam int FW    = 32;
    localparam int DEPTH = 4;
    localparam int SCW   = 4;
    localparam int DW    = NF * FW;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int SMAX  = (1 << SCW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_fields = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_fields;
    logic [LW-1:0] level;
    logic [SCW-1:0] stall_cnt;
`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
    logic          in_csum_chk = 1'b0;
    logic [FW-1:0] out_csum;
    logic          csum_err;
    logic [FW-1:0] csum_q[$];
    logic          m_csum_err = 1'b0;
`endif

    // model state
    logic [DW-1:0] exp_q[$];
    int            m_stall = 0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    amiq_dvcon_blue_field_buffer #(
        .NUM_FIELDS(NF), .FIELD_W(FW), .DEPTH(DEPTH), .STALL_CNT_W(SCW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_fields(in_fields),
        .out_valid(out_valid), .out_ready(out_ready), .out_fields(out_fields),
        .level(level), .stall_cnt(stall_cnt)
`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
        , .in_csum_chk(in_csum_chk), .out_csum(out_csum), .csum_err(csum_err)
`endif
    );

    function automatic logic [DW-1:0] beat(input int v);
        return {32'(v), 32'(v), 32'(v)};
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        return {$urandom, $urandom, $urandom};
    endfunction

    // One clock: decide the transfers from the current inputs and model
    // occupancy, advance the model, then settle #1 past the edge.
    task automatic cycle();
        bit do_push;
        bit do_pop;
        logic [FW-1:0] x;
        do_push = in_valid && (exp_q.size() < DEPTH);
        do_pop  = out_ready && (exp_q.size() > 0);
        x = '0;
        for (int i = 0; i < NF; i++) x = x ^ in_fields[i*FW +: FW];
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_stall = 0;
`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
            csum_q.delete();
            m_csum_err = 1'b0;
`endif
        end else begin
            if (in_valid && exp_q.size() == DEPTH && m_stall < SMAX) m_stall++;
            if (do_pop) begin
                void'(exp_q.pop_front());
`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
                void'(csum_q.pop_front());
`endif
            end
            if (do_push) begin
                exp_q.push_back(in_fields);
`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
                csum_q.push_back(x);
                if (in_csum_chk && x != '0) m_csum_err = 1'b1;
`endif
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (level !== LW'(0) || out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== SCW'(0)) begin
                failures++;
                $display("FAIL reset_idle c=%0d: level=%0d out_valid=%b in_ready=%b stall=%0d, want 0/0/1/0",
                         c, level, out_valid, in_ready, stall_cnt);
            end
            cycle();
        end
    endtask

    task automatic test_single_push();
        in_fields = {32'h3, 32'h2, 32'h1}; in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_fields !== 96'h00000003_00000002_00000001 || level !== LW'(1)) begin
            failures++;
            $display("FAIL single_push: out_valid=%b out_fields=%h level=%0d, want 1/000000030000000200000001/1",
                     out_valid, out_fields, level);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (level !== LW'(0) || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: level=%0d out_valid=%b, want 0/0", level, out_valid);
        end
    endtask

    task automatic test_full_stall();
        logic [DW-1:0] b[DEPTH];
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            b[k] = rand_beat();
            in_fields = b[k]; in_valid = 1'b1;
            cycle();
        end
        in_fields = rand_beat();
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (in_ready !== 1'b0 || level !== LW'(DEPTH) || stall_cnt !== SCW'(3)) begin
            failures++;
            $display("FAIL full_stall: in_ready=%b level=%0d stall=%0d, want 0/%0d/3",
                     in_ready, level, stall_cnt, DEPTH);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_fields !== b[k]) begin
                failures++;
                $display("FAIL full_drain k=%0d: out_valid=%b out_fields=%h, want 1/%h", k, out_valid, out_fields, b[k]);
            end
            cycle();
        end
        out_ready = 1'b0;
        checks++;
        if (level !== LW'(0) || stall_cnt !== SCW'(3)) begin
            failures++;
            $display("FAIL full_after: level=%0d stall=%0d, want 0/3", level, stall_cnt);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0; in_valid = 1'b1;
        in_fields = beat(0); cycle();
        in_fields = beat(1); cycle();
        out_ready = 1'b1;
        for (int v = 2; v < 10; v++) begin
            in_fields = beat(v);
            checks++;
            if (out_fields !== beat(v - 2) || level !== LW'(2)) begin
                failures++;
                $display("FAIL wrap v=%0d: out_fields=%h level=%0d, want %h/2", v, out_fields, level, beat(v - 2));
            end
            cycle();
        end
        in_valid = 1'b0;
        for (int v = 8; v < 10; v++) begin
            checks++;
            if (out_valid !== 1'b1 || out_fields !== beat(v)) begin
                failures++;
                $display("FAIL wrap_drain v=%0d: out_valid=%b out_fields=%h, want 1/%h", v, out_valid, out_fields, beat(v));
            end
            cycle();
        end
        out_ready = 1'b0;
        checks++;
        if (level !== LW'(0)) begin
            failures++;
            $display("FAIL wrap_end: level=%0d, want 0", level);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_fields = beat(100 + k); cycle();
        end
        rst = 1'b1; in_fields = beat(200); out_ready = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (level !== LW'(0) || out_valid !== 1'b0 || stall_cnt !== SCW'(0)) begin
            failures++;
            $display("FAIL reset_mid: level=%0d out_valid=%b stall=%0d, want 0/0/0", level, out_valid, stall_cnt);
        end
        in_valid = 1'b1;
        in_fields = beat(300); cycle();
        in_fields = beat(301); cycle();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_fields !== beat(300 + k)) begin
                failures++;
                $display("FAIL reset_mid_after k=%0d: out_valid=%b out_fields=%h, want 1/%h",
                         k, out_valid, out_fields, beat(300 + k));
            end
            cycle();
        end
        out_ready = 1'b0;
        checks++;
        if (level !== LW'(0) || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_end: level=%0d out_valid=%b, want 0/0", level, out_valid);
        end
    endtask

    task automatic test_stall_saturate();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        rst = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < DEPTH + 20; k++) begin
            in_fields = rand_beat();
            if (k >= DEPTH) in_fields = exp_q[DEPTH-1] ^ exp_q[DEPTH-1] ^ in_fields;
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (stall_cnt !== SCW'(SMAX)) begin
            failures++;
            $display("FAIL stall_saturate: stall=%0d, want %0d", stall_cnt, SMAX);
        end
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) cycle();
        out_ready = 1'b0;
        checks++;
        if (level !== LW'(0) || stall_cnt !== SCW'(SMAX)) begin
            failures++;
            $display("FAIL stall_hold: level=%0d stall=%0d, want 0/%0d", level, stall_cnt, SMAX);
        end
    endtask

`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
    task automatic test_csum();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        rst = 1'b0;
        in_csum_chk = 1'b1; in_valid = 1'b1;
        in_fields = {32'h3, 32'h2, 32'h1}; cycle();
        in_valid = 1'b0;
        checks++;
        if (out_csum !== 32'h0 || csum_err !== 1'b0) begin
            failures++;
            $display("FAIL csum_zero: out_csum=%h csum_err=%b, want 0/0", out_csum, csum_err);
        end
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        in_valid = 1'b1; in_fields = {32'h4, 32'h2, 32'h1}; cycle();
        in_valid = 1'b0; in_csum_chk = 1'b0;
        checks++;
        if (out_csum !== 32'h7 || csum_err !== 1'b1) begin
            failures++;
            $display("FAIL csum_err: out_csum=%h csum_err=%b, want 7/1", out_csum, csum_err);
        end
        out_ready = 1'b1; cycle(); cycle(); out_ready = 1'b0;
        checks++;
        if (csum_err !== 1'b1 || out_csum !== 32'h0) begin
            failures++;
            $display("FAIL csum_sticky: csum_err=%b out_csum=%h, want 1/0", csum_err, out_csum);
        end
        rst = 1'b1; cycle(); rst = 1'b0;
        checks++;
        if (csum_err !== 1'b0) begin
            failures++;
            $display("FAIL csum_clear: csum_err=%b, want 0", csum_err);
        end
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] exp_head;
        for (int c = 0; c < 400; c++) begin
            // a stalled producer keeps its beat; otherwise pick fresh stimulus
            if (!(in_valid && !in_ready)) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_fields = rand_beat();
            end
            out_ready = ($urandom_range(0, 2) == 0) || (c > 200 && $urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 99) == 0);
`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
            in_csum_chk = ($urandom_range(0, 7) == 0);
`endif
            cycle();
            rst = 1'b0;
            exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
            checks++;
            if (level !== LW'(exp_q.size()) || out_valid !== (exp_q.size() != 0) ||
                in_ready !== (exp_q.size() != DEPTH)) begin
                failures++;
                $display("FAIL rand_ctrl c=%0d: level=%0d out_valid=%b in_ready=%b, want level %0d",
                         c, level, out_valid, in_ready, exp_q.size());
            end
            checks++;
            if (out_fields !== exp_head) begin
                failures++;
                $display("FAIL rand_data c=%0d: out_fields=%h, want %h", c, out_fields, exp_head);
            end
            checks++;
            if (stall_cnt !== SCW'(m_stall)) begin
                failures++;
                $display("FAIL rand_stall c=%0d: stall=%0d, want %0d", c, stall_cnt, m_stall);
            end
`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
            checks++;
            if (out_csum !== ((csum_q.size() > 0) ? csum_q[0] : FW'(0)) || csum_err !== m_csum_err) begin
                failures++;
                $display("FAIL rand_csum c=%0d: out_csum=%h csum_err=%b, want err %b", c, out_csum, csum_err, m_csum_err);
            end
`endif
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full_stall();
        test_wrap();
        test_reset_mid();
        test_stall_saturate();
`ifdef AMIQ_DVCON_BLUE_FIELD_BUFFER_CSUM_EN
        test_csum();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
